// File: rtl/riscv_fetch_queue_pkg.sv
// rtl/riscv_fetch_queue_pkg.sv - shared types and constants for the fetch queue
package riscv_fetch_queue_pkg;

  localparam int XLEN = 32;

  // Sequential fetch advances one 32-bit instruction.
  localparam int PC_STEP = 4;

  // Canonical NOP (addi x0, x0, 0) for decode stages that want a benign
  // instruction presented while the queue head is invalid.
  localparam logic [XLEN-1:0] RISCV_NOP = 32'h0000_0013;

  // Queue entry layout at the native width: PC in the upper half.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - generic synchronous show-ahead FIFO with flush
module fetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [63:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  // Head reads as zero when empty so an idle queue never exposes stale data.
  assign head  = empty ? entry_t'('0) : mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(pop && empty));

endmodule

// File: rtl/riscv_fetch_queue.sv
// rtl/riscv_fetch_queue.sv - fetch PC, imem request credit and decode queue (option: FETCH_BYPASS_EN)
module riscv_fetch_queue
  import riscv_fetch_queue_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       redirect_in,
  input  logic [WIDTH-1:0]           redirect_pc_in,
  output logic                       imem_req_out,
  output logic [WIDTH-1:0]           imem_addr_out,
  input  logic [WIDTH-1:0]           imem_data_in,
  input  logic                       deq_ready_in,
  output logic                       instr_valid_out,
  output logic [WIDTH-1:0]           instr_out,
  output logic [WIDTH-1:0]           pc_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  logic [WIDTH-1:0] fetch_pc;
  logic             inflight;
  logic [WIDTH-1:0] inflight_pc;
  logic             deq_fire;
  logic [CW:0]      pending;
  logic             enq;
  logic             pop;
  entry_t           enq_data;
  entry_t           head;
  logic [CW-1:0]    q_count;
  logic             q_full;
  logic             q_empty;

  assign deq_fire = instr_valid_out && deq_ready_in;

  // Slots already owed: queued entries plus the response in flight, minus the one leaving now.
  assign pending = {1'b0, q_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, deq_fire};

  assign imem_req_out  = !rst_in && !redirect_in && (pending < DEPTH_W);
  assign imem_addr_out = fetch_pc;
  assign count_out     = q_count;
  assign enq_data      = '{pc: inflight_pc, instr: imem_data_in};
  // Only a real queue head is popped; a redirect makes the head wrong-path anyway.
  assign pop           = deq_fire && !redirect_in && !q_empty;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass = inflight && !redirect_in && q_empty;

  // Empty queue: the arriving response goes straight to decode and is only stored if not taken.
  always_comb begin
    instr_valid_out = !q_empty || bypass;
    instr_out       = bypass ? imem_data_in : head.instr;
    pc_out          = bypass ? inflight_pc  : head.pc;
    enq             = inflight && !redirect_in && !(bypass && deq_ready_in);
  end
`else
  // Decode always sees queue storage; every response is enqueued.
  always_comb begin
    instr_valid_out = !q_empty;
    instr_out       = head.instr;
    pc_out          = head.pc;
    enq             = inflight && !redirect_in;
  end
`endif

  // Fetch PC and in-flight tracking; redirect drops the outstanding response and re-aligns the target.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_in) begin
      fetch_pc <= {redirect_pc_in[WIDTH-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req_out;
      if (imem_req_out) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + WIDTH'(PC_STEP);
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .flush     (redirect_in),
    .push      (enq),
    .push_data (enq_data),
    .pop       (pop),
    .head      (head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// tb/tb_riscv_fetch_queue.sv - directed self-checking bench for riscv_fetch_queue
module tb_riscv_fetch_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             redirect = 1'b0;
  logic [WIDTH-1:0] redirect_pc = '0;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_data = '0;
  logic             deq_ready = 1'b0;
  logic             instr_valid;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] pc;
  logic [2:0]       count;

  int checks = 0;
  int errors = 0;

  riscv_fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .redirect_in     (redirect),
    .redirect_pc_in  (redirect_pc),
    .imem_req_out    (imem_req),
    .imem_addr_out   (imem_addr),
    .imem_data_in    (imem_data),
    .deq_ready_in    (deq_ready),
    .instr_valid_out (instr_valid),
    .instr_out       (instr),
    .pc_out          (pc),
    .count_out       (count)
  );

  always #5 clk = ~clk;

  // Synchronous-read imem model: word i holds 0x100+i; idle cycles return a poison value.
  always @(posedge clk) begin
    imem_data <= imem_req ? (32'h100 + (imem_addr >> 2)) : 32'hDEAD_BEEF;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect = 1'b0;
    deq_ready = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    deq_ready = 1'b1;
    step();
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
    checks++;
    if (instr !== 32'h0 || pc !== 32'h0) begin errors++; $display("FAIL reset_data: got instr %h pc %h want 0 0", instr, pc); end
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_first_req: got req %0b addr %h want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * c)) begin
        errors++; $display("FAIL stream_req c%0d: got req %0b addr %h want 1 %h", c, imem_req, imem_addr, 32'(4 * c));
      end
      checks++;
      if (instr_valid !== (c >= LAT)) begin
        errors++; $display("FAIL stream_valid c%0d: got %0b want %0b", c, instr_valid, c >= LAT);
      end else if (c >= LAT) begin
        checks++;
        if (pc !== 32'(4 * (c - LAT)) || instr !== 32'(32'h100 + c - LAT)) begin
          errors++; $display("FAIL stream_data c%0d: got pc %h instr %h want %h %h", c, pc, instr,
                             32'(4 * (c - LAT)), 32'(32'h100 + c - LAT));
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int exp_idx;
    do_reset();
    deq_ready = 1'b0;
    #1;
    for (int c = 0; c < 10; c++) step();
    checks++;
    if (count !== 3'd4) begin errors++; $display("FAIL bp_full_count: got %0d want 4", count); end
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_full_req: got %0b want 0", imem_req); end
    deq_ready = 1'b1;
    #1;
    exp_idx = 0;
    for (int c = 0; c < 14; c++) begin
      if (instr_valid === 1'b1) begin
        checks++;
        if (pc !== 32'(4 * exp_idx) || instr !== 32'(32'h100 + exp_idx)) begin
          errors++; $display("FAIL bp_order: got pc %h instr %h want %h %h", pc, instr,
                             32'(4 * exp_idx), 32'(32'h100 + exp_idx));
        end
        exp_idx++;
      end
      step();
    end
    checks++;
    if (exp_idx < 12) begin errors++; $display("FAIL bp_drain_rate: got %0d instrs want >= 12", exp_idx); end
  endtask

  task automatic test_redirect_full();
    bit found;
    do_reset();
    deq_ready = 1'b0;
    #1;
    for (int c = 0; c < 8; c++) step();
    deq_ready = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rd_credit_req: got %0b want 1", imem_req); end
    step();
    deq_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_same_cycle_req: got %0b want 0", imem_req); end
    step();
    redirect = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL rd_flush: got count %0d valid %0b want 0 0", count, instr_valid);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL rd_target_req: got req %0b addr %h want 1 00000040", imem_req, imem_addr);
    end
    deq_ready = 1'b1;
    #1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (instr_valid === 1'b1) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rd_first_valid: timeout waiting for valid");
    end else if (pc !== 32'h40 || instr !== 32'h110) begin
      errors++; $display("FAIL rd_first_valid: got pc %h instr %h want 00000040 00000110", pc, instr);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h44) begin
      errors++; $display("FAIL rd_second_valid: got valid %0b pc %h want 1 00000044", instr_valid, pc);
    end
  endtask

  task automatic test_redirect_align_b2b();
    bit found;
    do_reset();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h43;
    step();
    redirect = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL align_addr: got req %0b addr %h want 1 00000040", imem_req, imem_addr);
    end
    redirect = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect_pc = 32'hC0;
    step();
    redirect = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC0) begin
      errors++; $display("FAIL b2b_addr: got req %0b addr %h want 1 000000c0", imem_req, imem_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (instr_valid === 1'b1) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL b2b_first_valid: timeout waiting for valid");
    end else if (pc !== 32'hC0 || instr !== 32'h130) begin
      errors++; $display("FAIL b2b_first_valid: got pc %h instr %h want 000000c0 00000130", pc, instr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    deq_ready = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count: got %0d want 3", count); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_state: got count %0d valid %0b want 0 0", count, instr_valid);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL mid_reset_req: got req %0b addr %h want 1 00000000", imem_req, imem_addr);
    end
  endtask

`ifdef FETCH_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    step();
    for (int c = 1; c < 5; c++) begin
      checks++;
      if (instr_valid !== 1'b1 || pc !== 32'(4 * (c - 1)) || count !== 3'd0) begin
        errors++; $display("FAIL bypass c%0d: got valid %0b pc %h count %0d want 1 %h 0", c, instr_valid, pc,
                           count, 32'(4 * (c - 1)));
      end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_align_b2b();
    test_reset_mid();
`ifdef FETCH_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
